// File: rtl/dfe_pkg.sv
// ============================================================================
// Module      : dfe_pkg
// Description : Shared types, defaults and helpers for the DFE adaptation ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dfe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAIN  = 2'd1,
    SETTLE = 2'd2,
    TRACK  = 2'd3
  } dfe_adapt_state_t;

  localparam int c_SIGNAL_RESOLUTION = 8;
  localparam int c_TAP_WIDTH         = 8;

  // Clamp a + b into the signed range of a width-bit two's-complement value.
  function automatic int sat_add(input int a, input int b, input int width);
    int hi;
    int lo;
    int s;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    s  = a + b;
    if (s > hi)      sat_add = hi;
    else if (s < lo) sat_add = lo;
    else             sat_add = s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dfe_tap_lms.sv
// ============================================================================
// Module      : dfe_tap_lms
// Description : One DFE feedback tap with saturating sign-sign LMS update.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dfe_tap_lms
  import dfe_pkg::*;
#(
  parameter int TAP_WIDTH = c_TAP_WIDTH,
  parameter int STEP      = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_en,
  input  logic                        i_err_neg,
  input  logic                        i_dec_neg,
  output logic signed [TAP_WIDTH-1:0] o_tap
);

  logic signed [TAP_WIDTH-1:0] r_tap;
  logic signed [TAP_WIDTH-1:0] w_next;
  logic                        w_match;

  assign w_match = (i_err_neg == i_dec_neg);
  assign w_next  = TAP_WIDTH'(sat_add(int'(r_tap), w_match ? STEP : -STEP, TAP_WIDTH));

  always_ff @(posedge clk) begin
    if (!rstn)     r_tap <= '0;
    else if (i_en) r_tap <= w_next;
  end

  assign o_tap = r_tap;

endmodule

`default_nettype wire

// File: rtl/dfe_adapt_ctrl.sv
// ============================================================================
// Module      : dfe_adapt_ctrl
// Description : DFE training/tracking sequencer, tap owner and lock detector.
//               Define DFE_ADAPT_TRACK_EN to keep adapting taps in TRACK.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dfe_adapt_ctrl
  import dfe_pkg::*;
#(
  parameter int NUM_TAPS          = 2,
  parameter int SIGNAL_RESOLUTION = c_SIGNAL_RESOLUTION,
  parameter int TAP_WIDTH         = c_TAP_WIDTH,
  parameter int STEP              = 1,
  parameter int SETTLE_CYCLES     = 4,
  parameter int ERR_THRESH        = 4,
  parameter int LOCK_COUNT        = 16
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                i_start,
  input  logic                                i_abort,
  input  logic [15:0]                         i_train_len,
  input  logic signed [SIGNAL_RESOLUTION-1:0] i_err,
  input  logic                                i_err_valid,
  input  logic [NUM_TAPS-1:0]                 i_dec_sign,
  output logic                                o_mode_train,
  output logic [NUM_TAPS*TAP_WIDTH-1:0]       o_taps,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_locked
);

  localparam int c_SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int c_RUN_W = $clog2(LOCK_COUNT + 1);

  dfe_adapt_state_t r_state;
  dfe_adapt_state_t w_state_nxt;
  logic             w_done_nxt;
  logic             r_done;
  logic [15:0]      r_len;
  logic [15:0]      r_sym_cnt;
  logic [15:0]      w_sym_inc;
  logic [c_SET_W-1:0] r_settle_cnt;
  logic               w_settle_last;
  logic [c_RUN_W-1:0] r_run_cnt;
  logic [c_RUN_W-1:0] w_run_inc;
  logic               r_locked;
  logic [SIGNAL_RESOLUTION:0] w_err_ext;
  logic [SIGNAL_RESOLUTION:0] w_err_abs;
  logic w_err_neg;
  logic w_err_zero;
  logic w_in_thresh;
  logic w_start_acc;
  logic w_lock_state;
  logic w_adapt_state;
  logic w_tap_en;

  assign w_sym_inc     = r_sym_cnt + 16'd1;
  assign w_settle_last = (r_settle_cnt == c_SET_W'(SETTLE_CYCLES - 1));
  assign w_start_acc   = (r_state == IDLE) && i_start && !i_abort;

  // Widened by one bit so the most negative error maps to its true magnitude.
  assign w_err_neg   = i_err[SIGNAL_RESOLUTION-1];
  assign w_err_zero  = (i_err == '0);
  assign w_err_ext   = {i_err[SIGNAL_RESOLUTION-1], i_err};
  assign w_err_abs   = w_err_neg ? (~w_err_ext + 1'b1) : w_err_ext;
  assign w_in_thresh = (w_err_abs <= (SIGNAL_RESOLUTION + 1)'(ERR_THRESH));
  assign w_run_inc   = (r_run_cnt == c_RUN_W'(LOCK_COUNT)) ? r_run_cnt : r_run_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    if (i_abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            w_state_nxt = (i_train_len == 16'd0) ? SETTLE : TRAIN;
            w_done_nxt  = (i_train_len == 16'd0);
          end
        end
        TRAIN: begin
          if (i_err_valid && (w_sym_inc == r_len)) begin
            w_state_nxt = SETTLE;
            w_done_nxt  = 1'b1;
          end
        end
        SETTLE:  if (w_settle_last) w_state_nxt = TRACK;
        TRACK:   w_state_nxt = TRACK;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign w_lock_state = (r_state == TRAIN) || (r_state == TRACK);

  always_ff @(posedge clk) begin
    if (!rstn || i_abort) begin
      r_len        <= rstn ? r_len : 16'd0;
      r_sym_cnt    <= '0;
      r_settle_cnt <= '0;
      r_run_cnt    <= '0;
      r_locked     <= 1'b0;
    end else if (w_start_acc) begin
      r_len        <= i_train_len;
      r_sym_cnt    <= '0;
      r_settle_cnt <= '0;
      r_run_cnt    <= '0;
      r_locked     <= 1'b0;
    end else begin
      if ((r_state == TRAIN) && i_err_valid) r_sym_cnt <= w_sym_inc;
      if (r_state == SETTLE)
        r_settle_cnt <= w_settle_last ? '0 : r_settle_cnt + 1'b1;
      if (w_lock_state && i_err_valid) begin
        if (w_in_thresh) begin
          r_run_cnt <= w_run_inc;
          r_locked  <= r_locked | (w_run_inc == c_RUN_W'(LOCK_COUNT));
        end else begin
          r_run_cnt <= '0;
          r_locked  <= 1'b0;
        end
      end
    end
  end

`ifdef DFE_ADAPT_TRACK_EN
  assign w_adapt_state = (r_state == TRAIN) || (r_state == TRACK);
`else
  assign w_adapt_state = (r_state == TRAIN);
`endif

  assign w_tap_en = w_adapt_state && i_err_valid && !i_abort && !w_err_zero;

  generate
    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_tap
      dfe_tap_lms #(
        .TAP_WIDTH (TAP_WIDTH),
        .STEP      (STEP)
      ) u_tap (
        .clk       (clk),
        .rstn      (rstn),
        .i_en      (w_tap_en),
        .i_err_neg (w_err_neg),
        .i_dec_neg (i_dec_sign[g]),
        .o_tap     (o_taps[g*TAP_WIDTH +: TAP_WIDTH])
      );
    end
  endgenerate

  assign o_mode_train = (r_state == TRAIN);
  assign o_busy       = (r_state != IDLE);
  assign o_done       = r_done;
  assign o_locked     = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_dfe_adapt_ctrl.sv
// ============================================================================
// Module      : tb_dfe_adapt_ctrl
// Description : Directed scoreboard bench for dfe_adapt_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dfe_adapt_ctrl;

`ifdef DFE_ADAPT_TRACK_EN
  localparam bit c_TRK = 1'b1;
`else
  localparam bit c_TRK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic              abort;
  logic [15:0]       train_len;
  logic signed [7:0] err;
  logic              err_valid;
  logic [1:0]        dec_sign;
  logic              mode_train;
  logic [15:0]       taps;
  logic              busy;
  logic              done;
  logic              locked;

  dfe_adapt_ctrl u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_start      (start),
    .i_abort      (abort),
    .i_train_len  (train_len),
    .i_err        (err),
    .i_err_valid  (err_valid),
    .i_dec_sign   (dec_sign),
    .o_mode_train (mode_train),
    .o_taps       (taps),
    .o_busy       (busy),
    .o_done       (done),
    .o_locked     (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] taps;
    logic        locked;
  } exp_t;

  exp_t              q[$];
  logic signed [7:0] mt[2];
  int                mrun;
  logic              mlocked;
  int                npass = 0;
  int                ntot  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic signed [7:0] mupd(input logic signed [7:0] t,
                                             input logic signed [7:0] e, input logic d);
    int v;
    v = int'(t);
    if (e != 0) v = ((e < 0) == d) ? v + 1 : v - 1;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  // One valid error sample; expectation is pushed, then popped after the edge.
  task automatic send_sample(input logic signed [7:0] e, input logic [1:0] d,
                             input bit adapt, input bit lk, input string tag);
    exp_t x;
    int   a;
    err = e; dec_sign = d; err_valid = 1'b1;
    if (adapt) begin
      mt[0] = mupd(mt[0], e, d[0]);
      mt[1] = mupd(mt[1], e, d[1]);
    end
    if (lk) begin
      a = (e < 0) ? -int'(e) : int'(e);
      if (a <= 4) begin
        mrun = (mrun < 16) ? mrun + 1 : 16;
        if (mrun == 16) mlocked = 1'b1;
      end else begin
        mrun = 0;
        mlocked = 1'b0;
      end
    end
    q.push_back('{taps: {mt[1], mt[0]}, locked: mlocked});
    tick();
    err_valid = 1'b0;
    x = q.pop_front();
    chk({tag, "_taps"}, 32'(taps), 32'(x.taps));
    chk({tag, "_locked"}, 32'(locked), 32'(x.locked));
  endtask

  task automatic do_start(input logic [15:0] len);
    start = 1'b1; train_len = len;
    tick();
    start = 1'b0;
    mrun = 0; mlocked = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_mode", 32'(mode_train), (len != 0) ? 32'd1 : 32'd0);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    mrun = 0; mlocked = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mode", 32'(mode_train), 32'd0);
    chk("abort_locked", 32'(locked), 32'd0);
    chk("abort_taps", 32'(taps), 32'({mt[1], mt[0]}));
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; train_len = '0;
    err = '0; err_valid = 1'b0; dec_sign = '0;
    mt[0] = '0; mt[1] = '0; mrun = 0; mlocked = 1'b0;
    repeat (3) tick();
    chk("rst_taps", 32'(taps), 32'd0);
    chk("rst_mode", 32'(mode_train), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    rstn = 1'b1;
    tick();

    // Basic three-symbol training run.
    do_start(16'd3);
    for (int i = 0; i < 3; i++) begin
      send_sample(8'sd10, 2'b00, 1'b1, 1'b1, "train3");
      chk("train3_done", 32'(done), (i == 2) ? 32'd1 : 32'd0);
      chk("train3_mode", 32'(mode_train), (i == 2) ? 32'd0 : 32'd1);
    end
    chk("train3_taps33", 32'(taps), 32'h0303);
    tick();
    chk("train3_done_once", 32'(done), 32'd0);
    chk("train3_busy", 32'(busy), 32'd1);
    do_abort();

    // Positive then negative saturation.
    do_start(16'd200);
    for (int i = 0; i < 200; i++) send_sample(8'sd10, 2'b00, 1'b1, 1'b1, "satpos");
    chk("satpos_127", 32'(taps), 32'h7F7F);
    do_abort();
    do_start(16'd300);
    for (int i = 0; i < 300; i++) send_sample(8'sd10, 2'b11, 1'b1, 1'b1, "satneg");
    chk("satneg_m128", 32'(taps), 32'h8080);
    do_abort();

    // Zero error holds taps; lock after 16 in-threshold samples; lose it at -5.
    do_start(16'd30);
    for (int i = 0; i < 5; i++) send_sample(8'sd0, 2'b01, 1'b1, 1'b1, "zero");
    for (int i = 0; i < 11; i++) send_sample(8'sd4, 2'b00, 1'b1, 1'b1, "lock");
    chk("lock_set", 32'(locked), 32'd1);
    send_sample(-8'sd5, 2'b00, 1'b1, 1'b1, "unlock");
    chk("lock_clr", 32'(locked), 32'd0);
    do_abort();

    // Abort with a simultaneous start in the second TRAIN cycle.
    do_start(16'd10);
    send_sample(8'sd10, 2'b00, 1'b1, 1'b1, "pre_abort");
    abort = 1'b1; start = 1'b1; err = 8'sd10; err_valid = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0; err_valid = 1'b0;
    chk("abst_busy", 32'(busy), 32'd0);
    chk("abst_done", 32'(done), 32'd0);
    chk("abst_taps", 32'(taps), 32'({mt[1], mt[0]}));
    tick();
    chk("abst_idle", 32'(busy), 32'd0);

    // Abort on the exiting TRAIN sample suppresses done.
    do_start(16'd2);
    send_sample(8'sd10, 2'b10, 1'b1, 1'b1, "exit_abort");
    abort = 1'b1; err = 8'sd10; err_valid = 1'b1;
    tick();
    abort = 1'b0; err_valid = 1'b0;
    chk("exab_done", 32'(done), 32'd0);
    chk("exab_busy", 32'(busy), 32'd0);
    chk("exab_taps", 32'(taps), 32'({mt[1], mt[0]}));
    tick();
    chk("exab_done2", 32'(done), 32'd0);
    mrun = 0; mlocked = 1'b0;

    // Zero-length training: straight to SETTLE, TRACK after four cycles.
    do_start(16'd0);
    chk("len0_done", 32'(done), 32'd1);
    for (int i = 0; i < 4; i++) send_sample(8'sd4, 2'b00, 1'b0, 1'b0, "settle");
    chk("settle_done_low", 32'(done), 32'd0);
    for (int i = 0; i < 16; i++) send_sample(8'sd4, 2'b00, c_TRK, 1'b1, "track_lock");
    chk("track_locked", 32'(locked), 32'd1);
    send_sample(8'sd10, 2'b01, c_TRK, 1'b1, "track_upd");
    chk("track_busy", 32'(busy), 32'd1);
    do_abort();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dfe_adapt_ctrl.md
Name: dfe_adapt_ctrl

Overview:
- Sequencer and tap-coefficient owner for the DFE receive datapath.
- Runs the DFE in training mode for a programmed number of symbols, adapting feedback taps with sign-sign LMS, then hands off to decision-directed tracking.
- Publishes the current tap vector and the mode select that the DFE feedback path consumes.
- Sits between the Rx top-level control (start/abort) and the DFE slicer/subtractor.

Parameters:
- NUM_TAPS, 2, number of post-cursor feedback taps adapted.
- SIGNAL_RESOLUTION, 8, width of the signed error sample.
- TAP_WIDTH, 8, signed tap coefficient width; taps saturate to [-(2^(TAP_WIDTH-1)), 2^(TAP_WIDTH-1)-1].
- STEP, 1, tap increment in LSBs per update.
- SETTLE_CYCLES, 4, clock cycles of feedback-loop flush between TRAIN and TRACK.
- ERR_THRESH, 4, lock threshold on |err|.
- LOCK_COUNT, 16, consecutive in-threshold samples required for lock.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a training run from IDLE.
- abort  in  1  returns to IDLE; taps retained.
- train_len  in  16  training symbols; sampled on an accepted start.
- err  in  SIGNAL_RESOLUTION  signed slicer error e[n].
- err_valid  in  1  qualifies err and dec_sign.
- dec_sign  in  NUM_TAPS  sign of past decisions d[n-1..n-NUM_TAPS]; bit k-1 corresponds to d[n-k]; 1 = negative.
- mode_train  out  1  1 = DFE feedback uses train_data; 0 = uses decisions.
- taps  out  NUM_TAPS*TAP_WIDTH  packed taps; tap k-1 occupies slice [k*TAP_WIDTH-1 -: TAP_WIDTH].
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on the TRAIN->SETTLE transition.
- locked  out  1  convergence flag.

Behaviour:
- Reset values:
  - all taps 0.
  - mode_train=0, busy=0, done=0, locked=0.
  - state=IDLE, all counters 0.
- States: IDLE, TRAIN, SETTLE, TRACK.
- IDLE:
  - start=1 -> latch train_len.
  - If the latched length is 0, go to SETTLE and pulse done next cycle.
  - Otherwise go to TRAIN, with mode_train=1 from the next cycle.
- TRAIN:
  - Each err_valid: update taps, increment sym_cnt.
  - When sym_cnt reaches train_len on an err_valid, that sample is still applied, then go to SETTLE with done=1 for exactly one cycle.
  - mode_train drops to 0 on entry to SETTLE.
- SETTLE:
  - No tap updates; err_valid ignored.
  - Count SETTLE_CYCLES clocks, then go to TRACK.
- TRACK:
  - Adaptation per Optional Feature.
  - Remains in TRACK until abort or reset.
- Tap update, per tap k:
  - sign(e) = 0 when err=0 (no update).
  - tap_k += STEP when sign(err) == sign(d[n-k]); tap_k -= STEP otherwise.
  - Compute at TAP_WIDTH+1 bits and saturate; no wrap-around.
- Latency: the taps register updates the cycle after err_valid (1-cycle latency).
- Lock detection (TRAIN and TRACK):
  - |err| computed at SIGNAL_RESOLUTION+1 bits; the most negative err is treated as max magnitude.
  - On each err_valid: if |err| <= ERR_THRESH, increment the run counter (saturating at LOCK_COUNT); else clear it and deassert locked.
  - locked=1 once the run counter reaches LOCK_COUNT.
  - locked is cleared on start and abort.
- start while busy: ignored.
- abort:
  - Highest priority after reset; any state -> IDLE next cycle.
  - Clears mode_train, locked and counters; taps held.
  - abort and start in the same cycle -> abort wins.
  - abort on the cycle TRAIN would exit -> no done pulse.
- Reset mid-operation behaves identically to power-on reset.

Optional Feature:
- Macro DFE_ADAPT_TRACK_EN.
- Defined: TRACK applies sign-sign updates on every err_valid (decision-directed tracking).
- Undefined: taps freeze on leaving TRAIN; TRACK only updates the lock detector.

Decomposition:
- Shared package dfe_pkg holds:
  - state enum dfe_adapt_state_t {IDLE, TRAIN, SETTLE, TRACK}.
  - Default SIGNAL_RESOLUTION and TAP_WIDTH constants.
  - Saturating-add function sat_add.
- One sub-module, dfe_tap_lms: per-tap sign-sign update with saturation, instantiated NUM_TAPS times via generate.
- FSM, counters and lock detector stay in the top.

Test Plan:
- Reset, then start with train_len=3; drive 3 err_valid with err=+10, dec_sign=2'b00.
  - taps = {+3,+3}; done pulses once on the third sample's following cycle; mode_train is 1 for exactly the TRAIN window.
- Tap saturation: preload via training with err=+10, dec_sign=2'b00 for 200 symbols.
  - Both taps = +127 and never wrap. Repeat with dec_sign=2'b11: taps reach -128.
- err=0 on every sample for 5 symbols -> taps unchanged; lock run counter increments; after 16 in-threshold samples (err=+4), locked=1. One sample at err=-5 -> locked=0.
- abort in cycle 2 of TRAIN with start asserted simultaneously:
  - IDLE next cycle, no done, taps hold their values, busy=0.
- train_len=0 -> SETTLE directly with done pulse; TRACK reached after 4 cycles.
  - With DFE_ADAPT_TRACK_EN, an err=+10, dec_sign=2'b01 sample changes the taps by tap0 -1, tap1 +1.
  - Without the macro, the taps are unchanged.
